// File: rtl/instruction_encoder_loader_pkg.sv
// rtl/instruction_encoder_loader_pkg.sv - shared format codes, opcodes and FSM states for the instruction encoder loader
package instruction_encoder_loader_pkg;

    typedef enum logic [1:0] {
        FMT_R  = 2'b00,
        FMT_I  = 2'b01,
        FMT_S  = 2'b10,
        FMT_SB = 2'b11
    } fmt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic opcode_matches_fmt(input fmt_t f, input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (f)
            FMT_R:  ok = (op == OP_OP) || (op == OP_OP32);
            FMT_I:  ok = (op == OP_LOAD) || (op == OP_IMM) || (op == OP_IMM32) || (op == OP_JALR);
            FMT_S:  ok = (op == OP_STORE);
            FMT_SB: ok = (op == OP_BRANCH);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instruction_encoder_loader_insn_field_packer.sv
// rtl/instruction_encoder_loader_insn_field_packer.sv - combinational RV64I field tuple to 32-bit word packer
module insn_field_packer
    import instruction_encoder_loader_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word
);

    // Branch offsets are always even, so imm[0] carries no information.
    logic unused_imm0;
    assign unused_imm0 = imm[0];

    always_comb begin
        word = 32'h0;
        case (fmt_t'(fmt))
            FMT_R:  word = {func7, rs2, rs1, func3, rd, opcode};
            FMT_I:  word = {imm[11:0], rs1, func3, rd, opcode};
            FMT_S:  word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            FMT_SB: word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            default: word = 32'h0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder_loader.sv
// rtl/instruction_encoder_loader.sv - streams packed instructions into imem; optional opcode check via ENC_FMT_CHECK_EN
module instruction_encoder_loader
    import instruction_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_INSNS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [1:0]                     fmt,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [6:0]                     func7,
    input  logic [4:0]                     rd,
    input  logic [4:0]                     rs1,
    input  logic [4:0]                     rs2,
    input  logic [12:0]                    imm,
    output logic                           mem_we,
    input  logic                           mem_ready,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic [$clog2(MAX_INSNS+1)-1:0] count,
    output logic                           done,
    output logic                           fmt_err
);

    localparam int CNT_W = $clog2(MAX_INSNS + 1);

    state_t      state;
    logic        last_pend;
    logic [31:0] word;
    logic [CNT_W:0] inflight;
    logic        below_limit;
    logic        accept;
    logic        retire;
    logic        session_end;

    insn_field_packer u_packer (
        .fmt    (fmt),
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .word   (word)
    );

    // Written plus pending words; stops accepts once the limit is already spoken for.
    assign inflight    = {1'b0, count} + {{CNT_W{1'b0}}, mem_we};
    assign below_limit = inflight < (CNT_W+1)'(MAX_INSNS);

    assign in_ready    = (state == S_LOAD) && !last_pend && below_limit && (!mem_we || mem_ready);
    assign accept      = in_valid && in_ready;
    assign retire      = mem_we && mem_ready;
    assign session_end = retire && (last_pend || (count == CNT_W'(MAX_INSNS - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            last_pend <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(BASE_ADDR);
            mem_wdata <= 32'h0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        last_pend <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= ADDR_W'(BASE_ADDR);
                        count     <= '0;
                        done      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (retire) begin
                        count    <= count + CNT_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(4);
                    end
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= word;
                        last_pend <= in_last;
                    end else if (retire) begin
                        mem_we <= 1'b0;
                    end
                    if (session_end) begin
                        state  <= S_DONE;
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ENC_FMT_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_err <= 1'b0;
        end else if (start && (state != S_LOAD)) begin
            fmt_err <= 1'b0;
        end else if (accept && !opcode_matches_fmt(fmt_t'(fmt), opcode)) begin
            fmt_err <= 1'b1;
        end
    end
`else
    assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb/tb_instruction_encoder_loader.sv - self-checking bench for instruction_encoder_loader (limits 256 and 4)
module tb_instruction_encoder_loader;

    localparam int M0 = 256;
    localparam int M1 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        mem_ready = 1'b1;
    logic [1:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [12:0] imm = '0;

    logic        ir [2];
    logic        we [2];
    logic [9:0]  ad [2];
    logic [31:0] wd [2];
    logic        dn [2];
    logic        fe [2];
    logic [8:0]  cn0;
    logic [2:0]  cn1;

    always #5 clk = ~clk;

    instruction_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_INSNS(M0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ir[0]),
        .in_last(in_last), .fmt(fmt), .opcode(opcode), .func3(func3), .func7(func7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(we[0]), .mem_ready(mem_ready),
        .mem_addr(ad[0]), .mem_wdata(wd[0]), .count(cn0), .done(dn[0]), .fmt_err(fe[0])
    );

    instruction_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_INSNS(M1)) dut4 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ir[1]),
        .in_last(in_last), .fmt(fmt), .opcode(opcode), .func3(func3), .func7(func7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(we[1]), .mem_ready(mem_ready),
        .mem_addr(ad[1]), .mem_wdata(wd[1]), .count(cn1), .done(dn[1]), .fmt_err(fe[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Field placement by shift-and-add on integers, independent of any concatenation.
    function automatic logic [31:0] enc(input int f, input int op, input int f3, input int f7,
                                        input int r_d, input int r1, input int r2, input int im);
        longint w;
        w = op + (f3 << 12) + (r1 << 15);
        case (f)
            0: w += (r_d << 7) + (r2 << 20) + (f7 << 25);
            1: w += (r_d << 7) + ((im & 'hfff) << 20);
            2: w += ((im & 'h1f) << 7) + (r2 << 20) + (((im >> 5) & 'h7f) << 25);
            default: w += (((im >> 11) & 1) << 7) + (((im >> 1) & 'hf) << 8) + (r2 << 20)
                          + (((im >> 5) & 'h3f) << 25) + (((im >> 12) & 1) << 31);
        endcase
        return w[31:0];
    endfunction

    function automatic bit op_ok(input int f, input int op);
        case (f)
            0: return op inside {'h33, 'h3b};
            1: return op inside {'h03, 'h13, 'h1b, 'h67};
            2: return op == 'h23;
            default: return op == 'h63;
        endcase
    endfunction

    // Abstract model per instance: 0 idle, 1 loading, 2 done.
    int          st [2] = '{0, 0};
    int          cnt [2] = '{0, 0};
    int          addr [2] = '{0, 0};
    int          accn [2] = '{0, 0};
    bit          pend [2] = '{0, 0};
    bit          lastacc [2] = '{0, 0};
    bit          mferr [2] = '{0, 0};
    logic [31:0] pword [2] = '{0, 0};
    int          maxv [2] = '{M0, M1};
    bit          run = 1'b0;
    logic [31:0] log_d [$];
    int          log_a [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit er, a, r, wasl, eferr;
            int cv;
            er = (st[i] == 1) && !lastacc[i] && (accn[i] < maxv[i]) && (!pend[i] || mem_ready);
            cv = (i == 0) ? int'(cn0) : int'(cn1);
`ifdef ENC_FMT_CHECK_EN
            eferr = mferr[i];
`else
            eferr = 1'b0;
`endif
            if (run) begin
                chk($sformatf("in_ready[%0d]", i), ir[i], er);
                chk($sformatf("mem_we[%0d]", i), we[i], pend[i]);
                chk($sformatf("mem_addr[%0d]", i), ad[i], addr[i]);
                if (pend[i]) chk($sformatf("mem_wdata[%0d]", i), wd[i], pword[i]);
                chk($sformatf("count[%0d]", i), cv, cnt[i]);
                chk($sformatf("done[%0d]", i), dn[i], st[i] == 2);
                chk($sformatf("fmt_err[%0d]", i), fe[i], eferr);
                if (i == 0 && we[0] && mem_ready && !reset) begin
                    log_d.push_back(wd[0]);
                    log_a.push_back(int'(ad[0]));
                end
            end
            if (reset) begin
                st[i] = 0; cnt[i] = 0; addr[i] = 0; accn[i] = 0;
                pend[i] = 0; lastacc[i] = 0; mferr[i] = 0; pword[i] = 0;
            end else if (st[i] == 1) begin
                r = pend[i] && mem_ready;
                a = in_valid && er;
                wasl = lastacc[i];
                if (r) begin
                    cnt[i]++;
                    addr[i] = (addr[i] + 4) % 1024;
                end
                if (a) begin
                    pword[i] = enc(fmt, opcode, func3, func7, rd, rs1, rs2, imm);
                    pend[i] = 1;
                    accn[i]++;
                    if (in_last) lastacc[i] = 1;
                    if (!op_ok(fmt, opcode)) mferr[i] = 1;
                end else if (r) begin
                    pend[i] = 0;
                end
                if (r && (wasl || cnt[i] == maxv[i])) begin
                    st[i] = 2;
                    pend[i] = 0;
                end
            end else if (start) begin
                st[i] = 1; cnt[i] = 0; addr[i] = 0; accn[i] = 0;
                pend[i] = 0; lastacc[i] = 0; mferr[i] = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input int f, input int op, input int f3, input int f7,
                        input int r_d, input int r1, input int r2, input int im, input bit last);
        bit got, ok;
        fmt = f[1:0]; opcode = op[6:0]; func3 = f3[2:0]; func7 = f7[6:0];
        rd = r_d[4:0]; rs1 = r1[4:0]; rs2 = r2[4:0]; imm = im[12:0];
        in_last = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            got = ir[0];
            @(posedge clk);
            ok = got;
        end
        if (!ok) chk("send_timeout", 0, 1);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic prog5();
        send(0, 'h33, 0, 'h00, 5, 6, 7, 0, 0);
        send(0, 'h33, 0, 'h20, 4, 5, 0, 0, 0);
        send(1, 'h03, 3, 0, 9, 2, 0, 16, 0);
        send(2, 'h23, 3, 0, 0, 2, 9, 8, 0);
        send(3, 'h63, 0, 0, 0, 1, 2, 16, 1);
    endtask

    initial begin
        logic [31:0] lit [5];
        lit[0] = 32'h007302B3; lit[1] = 32'h40028233; lit[2] = 32'h01013483;
        lit[3] = 32'h00913423; lit[4] = 32'h00208863;

        chk("enc_r_add", enc(0, 'h33, 0, 0, 5, 6, 7, 0), lit[0]);
        chk("enc_r_sub", enc(0, 'h33, 0, 'h20, 4, 5, 0, 0), lit[1]);
        chk("enc_i_ld", enc(1, 'h03, 3, 0, 9, 2, 0, 16), lit[2]);
        chk("enc_s_sd", enc(2, 'h23, 3, 0, 0, 2, 9, 8), lit[3]);
        chk("enc_sb_beq", enc(3, 'h63, 0, 0, 0, 1, 2, 16), lit[4]);

        reset = 1'b1;
        tick(1);
        run = 1'b1;
        chk("rst_in_ready", ir[0], 0);
        chk("rst_mem_we", we[0], 0);
        chk("rst_mem_addr", ad[0], 0);
        chk("rst_mem_wdata", wd[0], 0);
        chk("rst_count", cn0, 0);
        chk("rst_done", dn[0], 0);
        chk("rst_fmt_err", fe[0], 0);
        reset = 1'b0;
        tick(1);

        // Five-instruction program, ready always high
        pulse_start();
        prog5();
        tick(3);
        chk("p1_done", dn[0], 1);
        chk("p1_count", cn0, 5);
        chk("p1_nwrites", log_d.size(), 5);
        for (int k = 0; k < 5 && k < log_d.size(); k++) begin
            chk($sformatf("p1_word%0d", k), log_d[k], lit[k]);
            chk($sformatf("p1_addr%0d", k), log_a[k], 4 * k);
        end
        chk("p1_lim_done", dn[1], 1);
        chk("p1_lim_count", cn1, 4);

        // Same program with imem back-pressure for three cycles mid-stream
        pulse_start();
        fork
            prog5();
            begin
                tick(3);
                mem_ready = 1'b0;
                tick(3);
                mem_ready = 1'b1;
            end
        join
        tick(3);
        chk("p2_nwrites", log_d.size(), 10);
        for (int k = 0; k < 5 && k + 5 < log_d.size(); k++) begin
            chk($sformatf("p2_word%0d", k), log_d[k + 5], lit[k]);
            chk($sformatf("p2_addr%0d", k), log_a[k + 5], 4 * k);
        end
        chk("p2_done", dn[0], 1);

        // Store format carrying an R opcode
        pulse_start();
        send(2, 'h33, 0, 0, 0, 1, 2, 4, 0);
        tick(1);
`ifdef ENC_FMT_CHECK_EN
        chk("fe_set", fe[0], 1);
`endif
        send(1, 'h13, 0, 0, 3, 3, 0, 1, 1);
        tick(2);
`ifdef ENC_FMT_CHECK_EN
        chk("fe_sticky", fe[0], 1);
`endif
        chk("fe_written", log_d[10], enc(2, 'h33, 0, 0, 0, 1, 2, 4));
        pulse_start();
        chk("fe_cleared", fe[0], 0);

        // Six tuples without in_last: the 4-limit instance stops after four
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send(1, 'h13, 0, 0, k + 1, 0, 0, k, 0);
            start = 1'b0;
        end
        tick(3);
        chk("lim_done", dn[1], 1);
        chk("lim_count", cn1, 4);
        chk("lim_ready", ir[1], 0);
        chk("big_count", cn0, 6);
        chk("big_not_done", dn[0], 0);

        // Reset while the large instance is still loading
        send(0, 'h33, 0, 0, 1, 2, 3, 0, 0);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_we", we[0], 0);
        chk("mid_rst_addr", ad[0], 0);
        chk("mid_rst_wdata", wd[0], 0);
        chk("mid_rst_count", cn0, 0);
        chk("mid_rst_ready", ir[0], 0);
        reset = 1'b0;
        tick(1);
        pulse_start();
        send(3, 'h63, 1, 0, 0, 3, 4, -8, 1);
        tick(3);
        chk("post_rst_done", dn[0], 1);
        chk("post_rst_count", cn0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
